// File: rtl/iq_readout_sched_pkg.sv
// Shared constants, types and frame helpers for the IQ readout scheduler.
// Frames are stored left-aligned so the bus always shifts out bits [127:120].
package iq_readout_sched_pkg;

  localparam int DATA_W       = 32;
  localparam int FRAME_W      = 128;
  localparam int FIFO_DEPTH   = 4;
  localparam int PTR_W        = 2;
  localparam int CNT_W        = 3;
  localparam int BYTES_PER_CH = 8;
  localparam int LEN_W        = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_ADVANCE = 2'd2
  } rd_state_e;

  typedef logic [FRAME_W-1:0] frame_t;

  // Per channel Q precedes I, RX1 precedes RX2; a single channel occupies the top half.
  function automatic frame_t pack_frame(input logic en1, input logic en2,
                                        input logic signed [DATA_W-1:0] i1,
                                        input logic signed [DATA_W-1:0] q1,
                                        input logic signed [DATA_W-1:0] i2,
                                        input logic signed [DATA_W-1:0] q2);
    if (en1 && en2) return {q1, i1, q2, i2};
    else if (en1)   return {q1, i1, 64'b0};
    else            return {q2, i2, 64'b0};
  endfunction

  function automatic logic [LEN_W-1:0] frame_len(input logic en1, input logic en2);
    return (en1 && en2) ? LEN_W'(2 * BYTES_PER_CH) : LEN_W'(BYTES_PER_CH);
  endfunction

endpackage

// File: rtl/iq_frame_fifo.sv
// 4-entry synchronous frame FIFO with first-word fall-through output.
// A pop on a full FIFO frees the slot, so a push in the same cycle is accepted.
module iq_frame_fifo
  import iq_readout_sched_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  frame_t           din,
  output frame_t           dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  frame_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (cnt_q == CNT_W'(FIFO_DEPTH));
    empty    = (cnt_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    dout     = mem_q[rd_ptr_q];
    count    = cnt_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/iq_readout_sched.sv
// Assembles RX1/RX2 IQ samples into frames, queues them, and serialises the
// head frame onto the MCU byte bus one byte per rd_strobe.
module iq_readout_sched
  import iq_readout_sched_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     rx1_en,
  input  logic                     rx2_en,
  input  logic                     rx1_valid,
  input  logic                     rx2_valid,
  input  logic signed [DATA_W-1:0] rx1_i,
  input  logic signed [DATA_W-1:0] rx1_q,
  input  logic signed [DATA_W-1:0] rx2_i,
  input  logic signed [DATA_W-1:0] rx2_q,
  input  logic                     rd_start,
  input  logic                     rd_strobe,
  input  logic                     clr_flags,
  output logic [7:0]               byte_out,
  output logic                     byte_oe,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic                     overflow,
  output logic                     underrun,
  output logic                     busy
);

  logic signed [DATA_W-1:0] rx1_i_hold_q, rx1_i_hold_d, rx1_q_hold_q, rx1_q_hold_d;
  logic signed [DATA_W-1:0] rx2_i_hold_q, rx2_i_hold_d, rx2_q_hold_q, rx2_q_hold_d;
  logic pend1_q, pend1_d, pend2_q, pend2_d, en1_q, en2_q;
  logic ovf_q, ovf_d, und_q, und_d;
  logic en_chg, push, pop;
  rd_state_e state_q, state_d;
  frame_t shift_q, shift_d, last_q, last_d, load_frame, fifo_dout;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic fifo_full, fifo_empty;

  iq_frame_fifo u_fifo (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .din    (pack_frame(rx1_en, rx2_en, rx1_i_hold_q, rx1_q_hold_q, rx2_i_hold_q, rx2_q_hold_q)),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (frame_cnt)
  );

  // A frame is pushed the cycle after its last channel goes pending; a fresh
  // strobe in that same cycle starts the next frame. Enable edges drop partials.
  always_comb begin
    en_chg       = (rx1_en != en1_q) || (rx2_en != en2_q);
    push         = (rx1_en || rx2_en) && (!rx1_en || pend1_q) && (!rx2_en || pend2_q) && !en_chg;
    rx1_i_hold_d = rx1_i_hold_q;
    rx1_q_hold_d = rx1_q_hold_q;
    rx2_i_hold_d = rx2_i_hold_q;
    rx2_q_hold_d = rx2_q_hold_q;
    pend1_d      = pend1_q && !push;
    pend2_d      = pend2_q && !push;
    if (rx1_en && rx1_valid) begin
      rx1_i_hold_d = rx1_i;
      rx1_q_hold_d = rx1_q;
      pend1_d      = 1'b1;
    end
    if (rx2_en && rx2_valid) begin
      rx2_i_hold_d = rx2_i;
      rx2_q_hold_d = rx2_q;
      pend2_d      = 1'b1;
    end
    if (en_chg) begin
      pend1_d = 1'b0;
      pend2_d = 1'b0;
    end
  end

  // An empty FIFO replays the last frame sent.
  always_comb begin
    pop        = rd_start && !fifo_empty;
    load_frame = fifo_empty ? last_q : fifo_dout;
    shift_d    = shift_q;
    rem_d      = rem_q;
    last_d     = last_q;
    if (rd_start) begin
      shift_d = load_frame;
      rem_d   = frame_len(rx1_en, rx2_en);
      last_d  = load_frame;
    end else if (rd_strobe && state_q != ST_IDLE && rem_q != '0) begin
      shift_d = shift_q << 8;
      rem_d   = rem_q - LEN_W'(1);
    end
    ovf_d = (push && fifo_full && !pop) || (ovf_q && !clr_flags);
    und_d = (rd_start && fifo_empty)    || (und_q && !clr_flags);
  end

  always_comb begin
    state_d = state_q;
    if (rd_start) state_d = ST_SEND;
    else begin
      case (state_q)
        ST_IDLE:    state_d = ST_IDLE;
        ST_SEND:    if (rd_strobe) state_d = ST_ADVANCE;
        ST_ADVANCE: if (rem_q == '0)   state_d = ST_IDLE;
                    else if (!rd_strobe) state_d = ST_SEND;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // ADVANCE with no bytes left is the one-cycle drain back to IDLE, bus released.
  always_comb begin
    byte_oe  = (state_q != ST_IDLE) && (rem_q != '0);
    busy     = byte_oe;
    byte_out = byte_oe ? shift_q[FRAME_W-1 -: 8] : 8'h00;
    overflow = ovf_q;
    underrun = und_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      rx1_i_hold_q <= '0;
      rx1_q_hold_q <= '0;
      rx2_i_hold_q <= '0;
      rx2_q_hold_q <= '0;
      pend1_q      <= 1'b0;
      pend2_q      <= 1'b0;
      en1_q        <= 1'b0;
      en2_q        <= 1'b0;
      shift_q      <= '0;
      rem_q        <= '0;
      last_q       <= '0;
      ovf_q        <= 1'b0;
      und_q        <= 1'b0;
    end else begin
      rx1_i_hold_q <= rx1_i_hold_d;
      rx1_q_hold_q <= rx1_q_hold_d;
      rx2_i_hold_q <= rx2_i_hold_d;
      rx2_q_hold_q <= rx2_q_hold_d;
      pend1_q      <= pend1_d;
      pend2_q      <= pend2_d;
      en1_q        <= rx1_en;
      en2_q        <= rx2_en;
      shift_q      <= shift_d;
      rem_q        <= rem_d;
      last_q       <= last_d;
      ovf_q        <= ovf_d;
      und_q        <= und_d;
    end
  end

endmodule

// File: doc/iq_readout_sched.md
IQ_READOUT_SCHED -- requirements
Module: iq_readout_sched

Interface
REQ-001 SHALL have ports: clk_in  in  1  sole clock; all logic rises on posedge clk_in.
REQ-002 SHALL have: rst_n  in  1  synchronous, active-low reset, sampled on posedge clk_in.
REQ-003 SHALL have: rx1_en, rx2_en  in  1 each  receiver enables; rx1_en=0 and rx2_en=0 means no frames are assembled.
REQ-004 SHALL have: rx1_valid, rx2_valid  in  1 each  single-cycle sample strobes, already synchronous to clk_in.
REQ-005 SHALL have: rx1_i, rx1_q, rx2_i, rx2_q  in  32 each  signed IQ samples, valid with their strobe.
REQ-006 SHALL have: rd_start  in  1  decoded "RX IQ" command pulse from the MCU bus decoder.
REQ-007 SHALL have: rd_strobe  in  1  one pulse per byte consumed by the MCU.
REQ-008 SHALL have: clr_flags  in  1  clears the sticky flags.
REQ-009 SHALL have: byte_out  out  8  current bus byte, and byte_oe  out  1  bus drive enable.
REQ-010 SHALL have: frame_cnt  out  3  FIFO occupancy, 0..4.
REQ-011 SHALL have: overflow, underrun  out  1 each  sticky flags.
REQ-012 SHALL have: busy  out  1  high while a frame is being sent.

Function
REQ-013 SHALL latch each enabled channel's I/Q into a holding register on its valid strobe, and SHALL set that channel's pending bit.
REQ-014 SHALL treat a repeat strobe on an already-pending channel as an overwrite: the newest sample is kept and no flag is raised.
REQ-015 SHALL form a frame when every enabled channel is pending: RX1 alone gives 64 bits, RX1+RX2 gives 128 bits. SHALL push the frame into a 4-entry FIFO on the next edge and clear the pending bits.
REQ-016 If rx2_en=0, SHALL push RX1-only frames; if rx1_en=0, SHALL build frames from RX2 only. Changing an enable SHALL clear all pending bits.
REQ-017 On a push while the FIFO is full (frame_cnt=4) with no pop that cycle, SHALL discard the new frame and set overflow. A simultaneous push and pop at full SHALL both succeed.
REQ-018 SHALL implement the read FSM with states IDLE, SEND, and ADVANCE. Transitions:
- IDLE to SEND on rd_start.
- SEND to ADVANCE on rd_strobe.
- ADVANCE to SEND when bytes remain.
- ADVANCE to IDLE after the last byte.
REQ-019 On rd_start with the FIFO non-empty, SHALL pop the head frame into the shift register. With the FIFO empty, SHALL resend the last transmitted frame (all-zero after reset) and set underrun.
REQ-020 SHALL present the first byte and assert byte_oe and busy exactly one clk_in after rd_start.
REQ-021 SHALL send bytes MSB first, per channel Q then I, RX1 before RX2, so one frame is 8 or 16 bytes (length fixed at pop time).
REQ-022 SHALL change byte_out exactly one clk_in after each rd_strobe.
REQ-023 After the last byte's rd_strobe, SHALL deassert byte_oe and busy on the next edge.
REQ-024 SHALL ignore rd_strobe while in IDLE.
REQ-025 On rd_start during SEND or ADVANCE, SHALL abort the current frame (no requeue) and restart per REQ-019.
REQ-026 When clr_flags and a flag-setting event occur in the same cycle, the flag SHALL end up set.
REQ-027 frame_cnt SHALL reflect the FIFO state registered after each edge, with a read pointer and a write pointer of 2 bits each that wrap modulo 4.

Reset
REQ-028 With rst_n=0 at a clock edge, SHALL clear the FIFO pointers, frame_cnt, pending bits, holding registers and last-frame register to 0.
REQ-029 Under reset, SHALL set the FSM to IDLE, byte_out=0, byte_oe=0, busy=0, overflow=0 and underrun=0.
REQ-030 A reset asserted mid-frame SHALL abort the frame and return the bus to high impedance on the following edge.

Structure
REQ-031 SHALL take the following constants from the shared transceiver package: FIFO depth 4, bytes per channel 8, and the FSM state encodings.
REQ-032 SHALL contain one sub-module, iq_frame_fifo (a 128-bit x 4 synchronous FIFO with full/empty/count); all other logic SHALL stay in this module.

Verification
REQ-033 Test "RX1-only readout": rx2_en=0; rx1_valid with I=0x11223344, Q=0x55667788; then rd_start plus 8 rd_strobe pulses. Required: bytes 55,66,77,88,11,22,33,44, then byte_oe=0.
REQ-034 Test "dual-channel readout": both channels enabled; RX2 sample I=0xA0A1A2A3, Q=0xB0B1B2B3 arrives before RX1. Required: one frame, 16 bytes, with RX1 bytes first and RX2 ending B0..B3,A0..A3.
REQ-035 Test "overflow": push 5 frames with no reads. Required: frame_cnt=4, overflow=1, and the fifth frame absent from the reads that follow.
REQ-036 Test "underrun": rd_start with the FIFO empty after one completed read. Required: the same 8 bytes are resent and underrun=1; clr_flags then gives underrun=0.
REQ-037 Test "abort": rd_start at byte 3 of a frame. Required: the next frame starts at its Q MSB one cycle later, and frame_cnt decrements by 1.
REQ-038 Test "reset mid-frame": rst_n=0 at byte 5. Required: next edge gives byte_oe=0, frame_cnt=0, and flags at 0.
